// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer at a time for bursts of up to
// MAX_BURST beats into the async FIFO, stalling on fifo_full without losing data.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [7:0]      beat_cnt_reg, beat_cnt_next;

  logic [GW-1:0]   grant_inc;
  logic [GW-1:0]   search_start;
  logic [GW:0]     pick;
  logic            active;
  logic            owner_valid;
  logic            beat;
  logic            release_now;
  logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];

  // Returns {found, index} of the first valid requester at or after start, wrapping.
  function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                          input logic [GW-1:0]      start);
    logic [GW:0] res;
    logic [GW:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, start} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (v[idx[GW-1:0]]) res = {1'b1, idx[GW-1:0]};
    end
    return res;
  endfunction

  assign grant_inc    = (grant_reg == GW'(NUM_REQ - 1)) ? '0 : grant_reg + GW'(1);
  assign search_start = (state_reg == GRANT) ? grant_inc : rr_ptr_reg;
  assign pick         = rr_pick(req_valid, search_start);

  // Reset gates the handshake combinationally so no beat moves in a reset cycle.
  assign active      = (state_reg == GRANT) && wrst_n;
  assign owner_valid = req_valid[grant_reg];
  assign beat        = active && owner_valid && !fifo_full;
  assign release_now = (beat && (beat_cnt_reg == 8'(MAX_BURST - 1))) || !owner_valid;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign data_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi]  = active && !fifo_full && (grant_reg == GW'(gi));
    end
  endgenerate

  assign fifo_wdata = data_slice[grant_reg];
  assign fifo_w_en  = beat;
  assign grant_id   = grant_reg;
  assign busy       = (state_reg == GRANT);

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick[GW]) begin
          state_next = GRANT;
          grant_next = pick[GW-1:0];
        end
      end
      GRANT: begin
        if (release_now) begin
          rr_ptr_next   = grant_inc;
          beat_cnt_next = '0;
          if (pick[GW]) grant_next = pick[GW-1:0];
          else          state_next = IDLE;
        end else if (beat) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

endmodule
